// File: rtl/game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_ctrl_pkg
// Shared definitions for the memory-game control unit: state encodings
// (also shown on the debug LEDs) and default button-conditioning parameters.
// -----------------------------------------------------------------------------
package game_ctrl_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_INIT   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SEQ    = 3'd2,
        ST_PLAY   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_RESULT = 3'd6
    } state_e;

    // 20 ms of stable level at 50 MHz
    localparam int DB_CNT_MAX_DEF  = 1_000_000;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/game_controller_button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns the raw, asynchronous, active-low ENTER button into a single-cycle
// press pulse: synchronizer chain -> debounce -> falling-edge detect.
//
// Ports:
//   CLOCK_50     in   system clock
//   RESET_N      in   asynchronous active-low reset
//   btn_n_raw    in   raw button, active-low, asynchronous
//   press_pulse  out  one-cycle pulse per accepted press (1->0 on the level)
//
// Latency from a clean press to the pulse is SYNC_STAGES + DB_CNT_MAX + 1.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DB_CNT_MAX  = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic btn_n_raw,
    output logic press_pulse
);

    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W = $clog2(DB_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

    logic [NSYNC-1:0] r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_q;
    logic             r_pulse;
    logic             w_sync;

    assign w_sync = r_sync[NSYNC-1];

    // Sync flops reset to the released level (1) so reset never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[NSYNC-2:0], btn_n_raw};
        end
    end

    // Accept a new level only after DB_CNT_MAX consecutive samples that differ
    // from the currently accepted level; any sample agreeing with it restarts.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (w_sync != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= w_sync;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered falling-edge detect on the accepted level.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stable_q <= 1'b1;
            r_pulse    <= 1'b0;
        end else begin
            r_stable_q <= r_stable;
            r_pulse    <= r_stable_q & ~r_stable;
        end
    end

    assign press_pulse = r_pulse;

endmodule

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Moore control FSM for the memory game. Drives the Datapath command inputs
// and reacts to its status outputs; ENTER is conditioned into a press pulse.
//
// Ports:
//   CLOCK_50, RESET_N             clock, asynchronous active-low reset
//   ENTER_N                       raw ENTER button (active-low, async)
//   end_FPGA, end_User, end_time  Datapath status
//   win, match                    Datapath status
//   R1, R2, E1..E4, SEL           Datapath commands (decoded from state only)
//   state_dbg                     current state encoding
// -----------------------------------------------------------------------------
module game_controller
    import game_ctrl_pkg::*;
#(
    parameter int DB_CNT_MAX  = DB_CNT_MAX_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            ENTER_N,
    input  logic            end_FPGA,
    input  logic            end_User,
    input  logic            end_time,
    input  logic            win,
    input  logic            match,
    output logic            R1,
    output logic            R2,
    output logic            E1,
    output logic            E2,
    output logic            E3,
    output logic            E4,
    output logic            SEL,
    output logic [ST_W-1:0] state_dbg
);

    state_e r_state;
    state_e w_next;
    logic   w_press;

    button_conditioner #(
        .DB_CNT_MAX  (DB_CNT_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .btn_n_raw   (ENTER_N),
        .press_pulse (w_press)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state. Press is only honoured in SETUP and RESULT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:   w_next = ST_SETUP;
            ST_SETUP:  if (w_press) w_next = ST_SEQ;
            ST_SEQ:    if (end_FPGA) w_next = ST_PLAY;
            ST_PLAY: begin
                // Timeout outranks everything, so a last entry arriving
                // together with expiry still loses.
                if (end_time)      w_next = ST_RESULT;
                else if (!match)   w_next = ST_RESULT;
                else if (end_User) w_next = ST_CHECK;
            end
            // win is looked at one cycle after end_User so Datapath can settle it.
            ST_CHECK:  w_next = win ? ST_RESULT : ST_NEXT;
            ST_NEXT:   w_next = ST_SEQ;
            ST_RESULT: if (w_press) w_next = ST_INIT;
            default:   w_next = ST_INIT;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (r_state)
            ST_SETUP:  E1 = 1'b1;
            ST_SEQ:    E2 = 1'b1;
            ST_PLAY:   E3 = 1'b1;
            ST_CHECK:  ;
            ST_NEXT: begin
                E4 = 1'b1;
                R2 = 1'b1;
            end
            ST_RESULT: SEL = 1'b1;
            default: begin
                // INIT and the unused encoding
                R1 = 1'b1;
                R2 = 1'b1;
            end
        endcase
    end

    assign state_dbg = r_state;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Directed stimulus with a scoreboard: each stimulus cycle queues the state
// and command outputs expected at the following falling edge; a monitor on
// the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_game_controller;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SEQ    = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter_n;
    logic       end_fpga, end_user, end_time, win, match;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_dbg;

    typedef struct {
        logic [2:0] st;
        logic [6:0] outs;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    game_controller #(.DB_CNT_MAX(4), .SYNC_STAGES(2)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .ENTER_N  (enter_n),
        .end_FPGA (end_fpga),
        .end_User (end_user),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_dbg(state_dbg)
    );

    // {R1,R2,E1,E2,E3,E4,SEL} per state, straight from the command table
    function automatic logic [6:0] exp_out(input logic [2:0] st);
        case (st)
            S_INIT:   return 7'b1100000;
            S_SETUP:  return 7'b0010000;
            S_SEQ:    return 7'b0001000;
            S_PLAY:   return 7'b0000100;
            S_CHECK:  return 7'b0000000;
            S_NEXT:   return 7'b0100010;
            S_RESULT: return 7'b0000001;
            default:  return 7'b1100000;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {R1, R2, E1, E2, E3, E4, SEL};
            n_checks++;
            if (state_dbg !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d at %0t", e.nm, state_dbg, e.st, $time);
            end
            n_checks++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL %s outputs {R1,R2,E1..E4,SEL}: got %b expected %b at %0t", e.nm, act, e.outs, $time);
            end
        end
    end

    // Queue the expectation for the coming falling edge, then advance one clock.
    task automatic tick(input logic [2:0] st, input string nm);
        exp_t e;
        e.st   = st;
        e.outs = exp_out(st);
        e.nm   = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic [2:0] st, input string nm);
        for (int i = 0; i < n; i++) tick(st, nm);
    endtask

    // Clean press: pulse lands SYNC+DB+1 = 7 edges after the drop, so the
    // state changes on the 8th edge; all 8 samples before it show cur.
    task automatic press_clean(input logic [2:0] cur, input string nm);
        enter_n = 1'b0;
        ticks(8, cur, nm);
        enter_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        enter_n  = 1'b1;
        end_fpga = 1'b0;
        end_user = 1'b0;
        end_time = 1'b0;
        win      = 1'b0;
        match    = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and release
        ticks(2, S_INIT, "reset");
        rst_n = 1'b1;
        tick(S_INIT, "rst_release");
        tick(S_SETUP, "setup_after_reset");

        // Bouncing press: low 2, high 1, then low 20 -> exactly one SETUP->SEQ
        for (int i = 0; i < 23; i++) begin
            enter_n = (i == 2);
            tick((i <= 10) ? S_SETUP : S_SEQ, "bounce_press");
        end
        enter_n = 1'b1;
        ticks(8, S_SEQ, "bounce_release");

        // Winning (non-final) round
        end_fpga = 1'b1;
        tick(S_SEQ, "seq_end_fpga");
        end_fpga = 1'b0;
        end_user = 1'b1;
        tick(S_PLAY, "play_end_user");
        end_user = 1'b0;
        win      = 1'b0;
        tick(S_CHECK, "check_nowin");
        tick(S_NEXT, "next_pulse");
        ticks(2, S_SEQ, "next_to_seq");

        // Asynchronous reset while in PLAY
        end_fpga = 1'b1;
        tick(S_SEQ, "seq_to_play");
        end_fpga = 1'b0;
        tick(S_PLAY, "play_idle");
        rst_n = 1'b0;
        ticks(3, S_INIT, "async_reset_play");
        rst_n = 1'b1;
        tick(S_INIT, "rst_release2");
        tick(S_SETUP, "setup_after_reset2");

        // Timeout and last entry together -> loss
        press_clean(S_SETUP, "setup_press");
        ticks(7, S_SEQ, "seq_wait");
        end_fpga = 1'b1;
        tick(S_SEQ, "seq_end_fpga2");
        end_fpga = 1'b0;
        end_time = 1'b1;
        end_user = 1'b1;
        tick(S_PLAY, "play_timeout_and_user");
        end_time = 1'b0;
        end_user = 1'b0;
        ticks(2, S_RESULT, "result_timeout");
        press_clean(S_RESULT, "result_press");
        tick(S_INIT, "init_after_result");
        ticks(7, S_SETUP, "setup_wait");

        // Mismatch, with a press held in PLAY that must be ignored
        press_clean(S_SETUP, "setup_press2");
        ticks(7, S_SEQ, "seq_wait2");
        end_fpga = 1'b1;
        tick(S_SEQ, "seq_end_fpga3");
        end_fpga = 1'b0;
        enter_n  = 1'b0;
        ticks(12, S_PLAY, "play_press_ignored");
        match = 1'b0;
        tick(S_PLAY, "play_mismatch");
        match = 1'b1;
        ticks(5, S_RESULT, "result_held_button");
        enter_n = 1'b1;
        ticks(7, S_RESULT, "result_release");

        // Final round won -> RESULT -> press -> INIT -> SETUP
        press_clean(S_RESULT, "result_press2");
        tick(S_INIT, "init_after_result2");
        ticks(7, S_SETUP, "setup_wait2");
        press_clean(S_SETUP, "setup_press3");
        ticks(7, S_SEQ, "seq_wait3");
        end_fpga = 1'b1;
        tick(S_SEQ, "seq_end_fpga4");
        end_fpga = 1'b0;
        end_user = 1'b1;
        tick(S_PLAY, "play_end_user2");
        end_user = 1'b0;
        win      = 1'b1;
        tick(S_CHECK, "check_win");
        win = 1'b0;
        ticks(7, S_RESULT, "result_win");
        press_clean(S_RESULT, "result_press3");
        tick(S_INIT, "init_final");
        tick(S_SETUP, "setup_final");

        // Drain the scoreboard with a bound
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
